mult_div_unit: RTL and testbench

Iterative multiply/divide unit owning the HI/LO register pair. It replaces single-cycle combinational `*`, `/` and `%` with a radix-2 shift-add multiplier and a restoring divider, parametrised in operand width. The unit sits beside the ALU in the execute stage. Control issues a request with a start/busy/done handshake and stalls MFHI/MFLO while `busy_o` is high.

---
 rtl/mult_div_unit_pkg.sv | 20 ++
 rtl/md_cond_negate.sv | 12 +
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 tb/tb_mult_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared opcode and state encodings for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_cond_negate.sv
// Conditional two's-complement: out_val = neg ? -in_val : in_val.
module md_cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_val,
  input  logic         neg,
  output logic [W-1:0] out_val
);

  assign out_val = neg ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 shift-add multiplier and restoring divider owning HI/LO.
// Handshake: a request is taken when start_i is high in a cycle where busy_o is low; busy_o stays high until the result lands, done_o pulses for one cycle when HI/LO hold the new result, and start_i during busy_o is dropped.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       state_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic               neg_q_q, neg_r_q, is_div_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_out_q;

  logic op_mul, op_div, op_signed, last_step;
  assign op_mul    = (op_i == MD_MULT) || (op_i == MD_MULTU);
  assign op_div    = (op_i == MD_DIV)  || (op_i == MD_DIVU);
  assign op_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign last_step = (cnt_q == CNT_W'(1));

  // Operand magnitudes; -2^(WIDTH-1) maps onto itself as an unsigned value.
  logic [WIDTH-1:0] mag_rs, mag_rt;
  md_cond_negate #(.W(WIDTH)) u_neg_rs (.in_val(rs_i), .neg(op_signed & rs_i[WIDTH-1]), .out_val(mag_rs));
  md_cond_negate #(.W(WIDTH)) u_neg_rt (.in_val(rt_i), .neg(op_signed & rt_i[WIDTH-1]), .out_val(mag_rt));

  // Result sign fixup taken straight off the accumulator.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  md_cond_negate #(.W(2*WIDTH)) u_neg_prod (.in_val(acc_q), .neg(neg_q_q), .out_val(prod_fix));
  md_cond_negate #(.W(WIDTH)) u_neg_quo (.in_val(acc_q[WIDTH-1:0]), .neg(neg_q_q), .out_val(quo_fix));
  md_cond_negate #(.W(WIDTH)) u_neg_rem (.in_val(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_r_q), .out_val(rem_fix));

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  assign mul_add = acc_q[0] ? opb_q : '0;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

  // Divide step: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_restore, div_unused;
  logic [WIDTH-1:0] div_rem;
  assign div_shift   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff    = {1'b0, div_shift} - {2'b00, opb_q};
  assign div_restore = div_diff[WIDTH+1];
  assign div_rem     = div_restore ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_unused  = div_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i && op_mul)      state_d = MUL;
        else if (start_i && op_div) state_d = DIV;
      end
      MUL:     if (last_step) state_d = FIXUP;
      DIV:     if (last_step) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (op_i == MD_MTHI) hi_q <= rs_i;
            if (op_i == MD_MTLO) lo_q <= rs_i;
            if (op_mul || op_div) begin
              cnt_q    <= CNT_W'(WIDTH);
              neg_q_q  <= op_signed & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
              neg_r_q  <= op_signed & op_div & rs_i[WIDTH-1];
              is_div_q <= op_div;
              dz_q     <= op_div && (rt_i == '0);
              acc_q    <= {{WIDTH{1'b0}}, (op_mul ? mag_rt : mag_rs)};
              opb_q    <= op_mul ? mag_rs : mag_rt;
            end
          end
        end
        MUL: begin
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        DIV: begin
          acc_q <= {div_rem, acc_q[WIDTH-2:0], ~div_restore};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIXUP: begin
          done_q <= 1'b1;
          if (!is_div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (dz_q) begin
            hi_q     <= '0;
            lo_q     <= '0;
            dz_out_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign div_by_zero_o = dz_out_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        start32, busy32, done32, dz32;
  logic [2:0]  op32;
  logic [31:0] rs32, rt32, hi32, lo32;
  logic [1:0]  st32;

  logic        start8, busy8, done8, dz8;
  logic [2:0]  op8;
  logic [7:0]  rs8, rt8, hi8, lo8;
  logic [1:0]  st8;

  mult_div_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset_i(reset), .start_i(start32), .op_i(op32), .rs_i(rs32), .rt_i(rt32),
    .busy_o(busy32), .done_o(done32), .div_by_zero_o(dz32), .hi_o(hi32), .lo_o(lo32), .state_o(st32)
  );

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_i(reset), .start_i(start8), .op_i(op8), .rs_i(rs8), .rt_i(rt8),
    .busy_o(busy8), .done_o(done8), .div_by_zero_o(dz8), .hi_o(hi8), .lo_o(lo8), .state_o(st8)
  );

  int checks = 0;
  int errors = 0;
  logic [64:0] exp32_q[$];   // {dz, hi, lo}
  logic [16:0] exp8_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!reset && done32) begin
      if (exp32_q.size() == 0) check("dut32 unexpected_done", 64'd1, 64'd0);
      else begin
        logic [64:0] e;
        e = exp32_q.pop_front();
        check("dut32 hi", 64'(hi32), 64'(e[63:32]));
        check("dut32 lo", 64'(lo32), 64'(e[31:0]));
        check("dut32 div_by_zero", 64'(dz32), 64'(e[64]));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done8) begin
      if (exp8_q.size() == 0) check("dut8 unexpected_done", 64'd1, 64'd0);
      else begin
        logic [16:0] e;
        e = exp8_q.pop_front();
        check("dut8 hi", 64'(hi8), 64'(e[15:8]));
        check("dut8 lo", 64'(lo8), 64'(e[7:0]));
        check("dut8 div_by_zero", 64'(dz8), 64'(e[16]));
      end
    end
  end

  // Driver: issue at a negedge, return at the negedge where done_o is visible.
  task automatic run_op(input bit sel8, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input int inject_at, input string name);
    int busy_n;
    bit seen;
    int exp_busy;
    busy_n   = 0;
    seen     = 1'b0;
    exp_busy = sel8 ? 9 : 33;
    if (sel8) begin
      exp8_q.push_back({edz, ehi[7:0], elo[7:0]});
      start8 = 1'b1; op8 = op; rs8 = rs[7:0]; rt8 = rt[7:0];
    end else begin
      exp32_q.push_back({edz, ehi, elo});
      start32 = 1'b1; op32 = op; rs32 = rs; rt32 = rt;
    end
    @(negedge clk);
    start8  = 1'b0;
    start32 = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (sel8 ? done8 : done32) begin
        seen = 1'b1;
        break;
      end
      if (sel8 ? busy8 : busy32) busy_n++;
      if (!sel8) begin
        start32 = (i == inject_at);
        op32    = MD_MTHI;
        rs32    = 32'h0000_AAAA;
      end
      @(negedge clk);
    end
    start8  = 1'b0;
    start32 = 1'b0;
    check({name, " done_seen"}, 64'(seen), 64'd1);
    check({name, " busy_cycles"}, 64'(busy_n), 64'(exp_busy));
  endtask

  task automatic move32(input logic [2:0] op, input logic [31:0] val, input string name);
    start32 = 1'b1; op32 = op; rs32 = val; rt32 = 32'h0;
    @(negedge clk);
    start32 = 1'b0;
    check({name, " busy"}, 64'(busy32), 64'd0);
    check({name, " done"}, 64'(done32), 64'd0);
    if (op == MD_MTHI) check({name, " hi"}, 64'(hi32), 64'(val));
    else               check({name, " lo"}, 64'(lo32), 64'(val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int late_dones;
    reset = 1'b1;
    start32 = 1'b0; op32 = MD_MULT; rs32 = '0; rt32 = '0;
    start8  = 1'b0; op8  = MD_MULT; rs8  = '0; rt8  = '0;
    repeat (3) @(negedge clk);
    check("reset hi32", 64'(hi32), 64'd0);
    check("reset lo32", 64'(lo32), 64'd0);
    check("reset busy32", 64'(busy32), 64'd0);
    check("reset done32", 64'(done32), 64'd0);
    check("reset dz32", 64'(dz32), 64'd0);
    check("reset state32", 64'(st32), 64'(IDLE));
    check("reset hi8", 64'(hi8), 64'd0);
    check("reset busy8", 64'(busy8), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    move32(MD_MTHI, 32'hDEAD_BEEF, "mthi");
    move32(MD_MTLO, 32'h0000_0005, "mtlo");

    // Back-to-back issue: each op starts in the previous op's done cycle.
    run_op(1'b0, MD_MULT,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0, "mult_m1x2");
    run_op(1'b0, MD_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 0, "multu_max_x2");
    run_op(1'b0, MD_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0,         32'h0000_000F, 1'b0, 0, "mult_neg_neg");
    run_op(1'b0, MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0,         1'b0, 0, "multu_2p32");
    run_op(1'b0, MD_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, "div_m7_2");
    run_op(1'b0, MD_DIVU,  32'h7,         32'h2,         32'h1,         32'h3,         1'b0, 0, "divu_7_2");
    run_op(1'b0, MD_DIV,   32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 1'b0, 0, "div_7_m2");
    run_op(1'b0, MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 0, "div_overflow");
    run_op(1'b0, MD_DIVU,  32'h7,         32'h0,         32'h0,         32'h0,         1'b1, 0, "divu_by_zero");
    run_op(1'b0, MD_DIV,   32'h5,         32'h0,         32'h0,         32'h0,         1'b1, 0, "div_by_zero");

    // MTHI arriving while busy must be dropped; MTLO in the done cycle is taken.
    run_op(1'b0, MD_MULTU, 32'h3, 32'h5, 32'h0, 32'hF, 1'b0, 10, "multu_busy_mthi");
    start32 = 1'b1; op32 = MD_MTLO; rs32 = 32'h0000_1234;
    @(negedge clk);
    start32 = 1'b0;
    check("mtlo_in_done lo", 64'(lo32), 64'h1234);
    check("mtlo_in_done hi", 64'(hi32), 64'h0);
    check("mtlo_in_done busy", 64'(busy32), 64'd0);

    run_op(1'b1, MD_MULT,  32'h80, 32'h80, 32'h40, 32'h00, 1'b0, 0, "w8_mult_min_sq");
    run_op(1'b1, MD_DIV,   32'h81, 32'h03, 32'hFF, 32'hD6, 1'b0, 0, "w8_div_81_3");
    run_op(1'b1, MD_MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0, 0, "w8_multu_ff");
    run_op(1'b1, MD_DIVU,  32'hFF, 32'h10, 32'h0F, 32'h0F, 1'b0, 0, "w8_divu_ff_10");

    // Reset during a divide: nothing from it may reach HI/LO or done_o.
    start32 = 1'b1; op32 = MD_DIV; rs32 = 32'd100; rt32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_reset busy32", 64'(busy32), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy32", 64'(busy32), 64'd0);
    check("abort done32", 64'(done32), 64'd0);
    check("abort hi32", 64'(hi32), 64'd0);
    check("abort lo32", 64'(lo32), 64'd0);
    check("abort lo8", 64'(lo8), 64'd0);
    reset = 1'b0;
    late_dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (done32) late_dones++;
    end
    check("abort late_done_count", 64'(late_dones), 64'd0);
    check("abort lo32_after", 64'(lo32), 64'd0);

    check("scoreboard32 drained", 64'(exp32_q.size()), 64'd0);
    check("scoreboard8 drained", 64'(exp8_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
